// File: rtl/hex_scroll_ctrl.sv
// hex_scroll_ctrl
//   Scrolls the 8-slot message "d E 1 0 2 _ _ _" across NUM_DISP seven-segment
//   displays. Each display gets a 3-bit character code:
//   000=d, 001=E, 010=1, 011=0, 100=2, 111=blank.
//   Scrolling is automatic (one step every TICK_DIV clocks) while run=1, or
//   manual (one step per rising edge of the step key) while run=0.
module hex_scroll_ctrl #(
  parameter int unsigned NUM_DISP = 6,
  parameter int unsigned TICK_DIV = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  dir,
  input  logic                  step,
  input  logic                  restart,
  output logic [3*NUM_DISP-1:0] codes,
  output logic [2:0]            offset,
  output logic                  tick,
  output logic                  busy
);

  localparam int unsigned MSG_LEN = 8;
  localparam int unsigned OFS_W   = 3;
  localparam int unsigned CNT_W   = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             step_q;
  logic             step_edge;
  logic             advance;
  logic [2:0]       msg [MSG_LEN];

  // Fixed message table, slot 0 is the leftmost character at offset 0.
  always_comb begin
    msg[0] = 3'b000;  // d
    msg[1] = 3'b001;  // E
    msg[2] = 3'b010;  // 1
    msg[3] = 3'b011;  // 0
    msg[4] = 3'b100;  // 2
    msg[5] = 3'b111;  // blank
    msg[6] = 3'b111;  // blank
    msg[7] = 3'b111;  // blank
  end

  assign step_edge = step & ~step_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STOPPED;
    end else begin
      state <= state_next;
    end
  end

  // Next-state, step counter and advance decision; restart overrides both
  // the counter and any advance but leaves the state to follow run.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    advance    = 1'b0;
    busy       = 1'b0;
    case (state)
      STOPPED: begin
        cnt_next = '0;
        if (run) begin
          state_next = RUNNING;
        end else if (step_edge) begin
          advance = 1'b1;
        end
      end
      RUNNING: begin
        busy = 1'b1;
        if (!run) begin
          state_next = STOPPED;
          cnt_next   = '0;
        end else if (cnt == CNT_MAX) begin
          cnt_next = '0;
          advance  = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = STOPPED;
        cnt_next   = '0;
      end
    endcase
    if (restart) begin
      cnt_next = '0;
      advance  = 1'b0;
    end
  end

  // Counter, key history, offset and tick pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      step_q <= 1'b0;
      offset <= '0;
      tick   <= 1'b0;
    end else begin
      cnt    <= cnt_next;
      step_q <= step;
      tick   <= advance;
      if (restart) begin
        offset <= '0;
      end else if (advance) begin
        offset <= dir ? offset - OFS_W'(1) : offset + OFS_W'(1);
      end
    end
  end

  // Display k shows message slot (offset + NUM_DISP-1-k) mod 8; the 3-bit
  // add wraps naturally, so no explicit modulo is needed.
  always_comb begin
    codes = '0;
    for (int unsigned k = 0; k < NUM_DISP; k++) begin
      codes[3*k +: 3] = msg[offset + OFS_W'(NUM_DISP - 1 - k)];
    end
  end

endmodule
